// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port memory between fetch (IF) and data (DM) stages.
// Latency: 1 IDLE + N BUSY (N>=1, N<=TIMEOUT) + 1 RESP cycle; throughput one access per 3 cycles best case.
// Backpressure: stall_f/stall_m held until the matching one-cycle valid pulse; memory throttles via mem_ready.
// Optional feature macro: UMA_ROUND_ROBIN_EN (round-robin on simultaneous requests; default fixed DM priority).

module unified_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  // fetch stage
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  // data stage
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  // memory side
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  // hazard unit / status
  output logic              stall_f,
  output logic              stall_m,
  output logic              bus_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Abort fires on the BUSY cycle whose miss would bring the wait count to TIMEOUT,
  // so an unanswered access occupies exactly TIMEOUT BUSY cycles.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] wait_cnt;
  logic       pick_d;
  logic       pick_i;

`ifdef UMA_ROUND_ROBIN_EN
  // 1 = data stage was granted most recently, 0 = fetch stage (reset value).
  logic       owner_dm;

  // Grant selection in IDLE: alternate on a tie, lone requester always wins.
  always_comb begin
    pick_d = 1'b0;
    pick_i = 1'b0;
    if (dm_req && if_req) begin
      if (owner_dm) begin
        pick_i = 1'b1;
      end else begin
        pick_d = 1'b1;
      end
    end else begin
      pick_d = dm_req;
      pick_i = if_req;
    end
  end

  // Remember who was granted at each BUSY entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_dm <= 1'b0;
    end else if (state == IDLE && (pick_d || pick_i)) begin
      owner_dm <= pick_d;
    end
  end
`else
  // Grant selection in IDLE: the data access is the older instruction, so it wins ties.
  always_comb begin
    pick_d = dm_req;
    pick_i = if_req & ~dm_req;
  end
`endif

  // A stage stalls from its request until the cycle its completion pulse is seen.
  always_comb begin
    stall_f = if_req & ~if_valid;
    stall_m = dm_req & ~dm_valid;
  end

  // Access sequencer: latch request on grant, wait for mem_ready or timeout, pulse response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      if_valid  <= 1'b0;
      dm_rdata  <= '0;
      dm_valid  <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      // Completion and error flags are single-cycle pulses by default.
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      bus_err  <= 1'b0;

      case (state)
        IDLE: begin
          if (pick_d) begin
            state     <= BUSY_D;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            wait_cnt  <= '0;
          end else if (pick_i) begin
            state     <= BUSY_I;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            wait_cnt  <= '0;
          end
        end

        BUSY_I, BUSY_D: begin
          if (mem_ready) begin
            // Normal completion: hand the read data to whichever stage owns the access.
            state   <= RESP;
            mem_req <= 1'b0;
            if (state == BUSY_I) begin
              if_rdata <= mem_rdata;
              if_valid <= 1'b1;
            end else begin
              dm_rdata <= mem_rdata;
              dm_valid <= 1'b1;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            // Memory never answered: complete with zero data so the pipeline keeps moving.
            state    <= RESP;
            mem_req  <= 1'b0;
            bus_err  <= 1'b1;
            wait_cnt <= wait_cnt + 8'd1;
            if (state == BUSY_I) begin
              if_rdata <= '0;
              if_valid <= 1'b1;
            end else begin
              dm_rdata <= '0;
              dm_valid <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        RESP: begin
          // Requester updates its request at this edge; re-arbitrate from IDLE.
          state <= IDLE;
        end

        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: per-cycle vector table plus hand-written timeout and tie sequences.
// Inputs are driven 1 ns after each rising edge; outputs are checked 1 ns after the next edge.
// Expected values are hand-computed from the access protocol.

module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [31:0] dm_rdata;
  logic        dm_valid;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        stall_f;
  logic        stall_m;
  logic        bus_err;

  int n_chk  = 0;
  int n_fail = 0;

  unified_mem_arbiter #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(15)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_valid (if_valid),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata),
    .dm_valid (dm_valid),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .stall_f  (stall_f),
    .stall_m  (stall_m),
    .bus_err  (bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ifq;
    logic [31:0] ifa;
    logic        dq;
    logic        dwe;
    logic [31:0] da;
    logic [31:0] dwd;
    logic [31:0] mrd;
    logic        mrdy;
    logic        e_mreq;
    logic        e_mwe;
    logic [31:0] e_maddr;
    logic        e_iv;
    logic [31:0] e_ird;
    logic        e_dv;
    logic [31:0] e_drd;
    logic        e_sf;
    logic        e_sm;
    logic        e_be;
  } vec_t;

  vec_t tbl[$];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic addv(
    input logic r, input logic ifq, input logic [31:0] ifa,
    input logic dq, input logic dwe, input logic [31:0] da, input logic [31:0] dwd,
    input logic [31:0] mrd, input logic mrdy,
    input logic emq, input logic emwe, input logic [31:0] ema,
    input logic eiv, input logic [31:0] eird, input logic edv, input logic [31:0] edrd,
    input logic esf, input logic esm, input logic ebe);
    vec_t v;
    v.rst = r;      v.ifq = ifq;    v.ifa = ifa;
    v.dq = dq;      v.dwe = dwe;    v.da = da;      v.dwd = dwd;
    v.mrd = mrd;    v.mrdy = mrdy;
    v.e_mreq = emq; v.e_mwe = emwe; v.e_maddr = ema;
    v.e_iv = eiv;   v.e_ird = eird; v.e_dv = edv;   v.e_drd = edrd;
    v.e_sf = esf;   v.e_sm = esm;   v.e_be = ebe;
    tbl.push_back(v);
  endtask

  task automatic drive_idle();
    rst = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    mem_ready = 1'b0; mem_rdata = '0;
  endtask

`ifdef UMA_ROUND_ROBIN_EN
  localparam bit TIE_IF_FIRST = 1'b1;
`else
  localparam bit TIE_IF_FIRST = 1'b0;
`endif

  initial begin : main
    int busy;
    bit done;

    //    rst ifq ifa    dq dwe da     dwd           mrd           rdy | mreq mwe maddr iv ird           dv drd           sf sm be
    // reset with fetch pending
    addv(1, 1, 'h10,  0, 0, 'h0,   'h0,          'h0,          0,   0, 0, 'h0,   0, 'h0,          0, 'h0,          1, 0, 0);
    addv(1, 1, 'h10,  0, 0, 'h0,   'h0,          'h0,          0,   0, 0, 'h0,   0, 'h0,          0, 'h0,          1, 0, 0);
    // fetch, memory answers on first BUSY cycle
    addv(0, 1, 'h10,  0, 0, 'h0,   'h0,          'h0,          0,   1, 0, 'h10,  0, 'h0,          0, 'h0,          1, 0, 0);
    addv(0, 1, 'h10,  0, 0, 'h0,   'h0,          32'hE3A01005, 1,   0, 0, 'h0,   1, 32'hE3A01005, 0, 'h0,          0, 0, 0);
    addv(0, 0, 'h0,   0, 0, 'h0,   'h0,          'h0,          0,   0, 0, 'h0,   0, 'h0,          0, 'h0,          0, 0, 0);
    // mem_ready while IDLE with no request is ignored
    addv(0, 0, 'h0,   0, 0, 'h0,   'h0,          32'h12345678, 1,   0, 0, 'h0,   0, 'h0,          0, 'h0,          0, 0, 0);
    // simultaneous store and fetch: store first, fetch next
    addv(0, 1, 'h20,  1, 1, 'h100, 32'hDEADBEEF, 'h0,          0,   1, 1, 'h100, 0, 'h0,          0, 'h0,          1, 1, 0);
    addv(0, 1, 'h20,  1, 1, 'h100, 32'hDEADBEEF, 32'hAAAA5555, 1,   0, 0, 'h0,   0, 'h0,          1, 32'hAAAA5555, 1, 0, 0);
    addv(0, 1, 'h20,  0, 0, 'h0,   'h0,          'h0,          1,   0, 0, 'h0,   0, 'h0,          0, 'h0,          1, 0, 0);
    addv(0, 1, 'h20,  0, 0, 'h0,   'h0,          'h0,          0,   1, 0, 'h20,  0, 'h0,          0, 'h0,          1, 0, 0);
    addv(0, 1, 'h20,  0, 0, 'h0,   'h0,          32'h11112222, 1,   0, 0, 'h0,   1, 32'h11112222, 0, 'h0,          0, 0, 0);
    addv(0, 0, 'h0,   0, 0, 'h0,   'h0,          'h0,          0,   0, 0, 'h0,   0, 'h0,          0, 'h0,          0, 0, 0);
    // reset during BUSY_I abandons the fetch
    addv(0, 1, 'h30,  0, 0, 'h0,   'h0,          'h0,          0,   1, 0, 'h30,  0, 'h0,          0, 'h0,          1, 0, 0);
    addv(1, 1, 'h30,  0, 0, 'h0,   'h0,          'h99,         1,   0, 0, 'h0,   0, 'h0,          0, 'h0,          1, 0, 0);
    addv(0, 0, 'h0,   0, 0, 'h0,   'h0,          'h0,          0,   0, 0, 'h0,   0, 'h0,          0, 'h0,          0, 0, 0);
    // lone load
    addv(0, 0, 'h0,   1, 0, 'h200, 'h0,          'h0,          0,   1, 0, 'h200, 0, 'h0,          0, 'h0,          0, 1, 0);
    addv(0, 0, 'h0,   1, 0, 'h200, 'h0,          32'hCAFEF00D, 1,   0, 0, 'h0,   0, 'h0,          1, 32'hCAFEF00D, 0, 0, 0);
    addv(0, 0, 'h0,   0, 0, 'h0,   'h0,          'h0,          0,   0, 0, 'h0,   0, 'h0,          0, 'h0,          0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst;   if_req = tbl[i].ifq; if_addr = tbl[i].ifa;
      dm_req = tbl[i].dq; dm_we = tbl[i].dwe;  dm_addr = tbl[i].da; dm_wdata = tbl[i].dwd;
      mem_rdata = tbl[i].mrd; mem_ready = tbl[i].mrdy;
      tick();
      chk1($sformatf("v%0d mem_req", i), mem_req, tbl[i].e_mreq);
      if (tbl[i].e_mreq) begin
        chk1($sformatf("v%0d mem_we", i), mem_we, tbl[i].e_mwe);
        chk32($sformatf("v%0d mem_addr", i), mem_addr, tbl[i].e_maddr);
        if (tbl[i].e_mwe) chk32($sformatf("v%0d mem_wdata", i), mem_wdata, tbl[i].dwd);
      end
      chk1($sformatf("v%0d if_valid", i), if_valid, tbl[i].e_iv);
      if (tbl[i].e_iv) chk32($sformatf("v%0d if_rdata", i), if_rdata, tbl[i].e_ird);
      chk1($sformatf("v%0d dm_valid", i), dm_valid, tbl[i].e_dv);
      if (tbl[i].e_dv) chk32($sformatf("v%0d dm_rdata", i), dm_rdata, tbl[i].e_drd);
      chk1($sformatf("v%0d stall_f", i), stall_f, tbl[i].e_sf);
      chk1($sformatf("v%0d stall_m", i), stall_m, tbl[i].e_sm);
      chk1($sformatf("v%0d bus_err", i), bus_err, tbl[i].e_be);
    end

    // Timeout: memory never answers a load; expect 15 BUSY cycles then an error response.
    drive_idle();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
    busy = 0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      tick();
      if (mem_req) busy++;
      if (dm_valid) done = 1'b1;
    end
    chk1("timeout completed", done, 1'b1);
    chk32("timeout busy cycles", 32'(busy), 32'd15);
    chk32("timeout dm_rdata", dm_rdata, 32'h0);
    chk1("timeout bus_err", bus_err, 1'b1);
    dm_req = 1'b0;
    tick();
    chk1("post-timeout bus_err", bus_err, 1'b0);
    chk1("post-timeout dm_valid", dm_valid, 1'b0);
    chk1("post-timeout mem_req", mem_req, 1'b0);

    // Tie after a data-stage access: round-robin serves fetch first, fixed priority serves data.
    if_req = 1'b1; if_addr = 32'h40;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h500;
    tick();
    chk32("tie first addr", mem_addr, TIE_IF_FIRST ? 32'h40 : 32'h500);
    mem_ready = 1'b1; mem_rdata = 32'h0000_0055;
    tick();
    chk1("tie first if_valid", if_valid, TIE_IF_FIRST);
    chk1("tie first dm_valid", dm_valid, !TIE_IF_FIRST);
    if (TIE_IF_FIRST) if_req = 1'b0; else dm_req = 1'b0;
    mem_ready = 1'b0;
    tick();
    tick();
    chk1("tie second mem_req", mem_req, 1'b1);
    chk32("tie second addr", mem_addr, TIE_IF_FIRST ? 32'h500 : 32'h40);
    mem_ready = 1'b1; mem_rdata = 32'h0000_0066;
    tick();
    chk1("tie second if_valid", if_valid, !TIE_IF_FIRST);
    chk1("tie second dm_valid", dm_valid, TIE_IF_FIRST);
    chk32("tie second rdata", TIE_IF_FIRST ? dm_rdata : if_rdata, 32'h0000_0066);
    drive_idle();
    tick();
    chk1("final mem_req", mem_req, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
